// File: rtl/request_unit_pkg.sv
// request_unit_pkg: shared types and defaults for the memory request unit.
// Optional feature macro REQ_TIMEOUT_EN is consumed by request_unit_if and request_unit.
package request_unit_pkg;

   localparam int unsigned CNT_W_DEF          = 32;
   localparam int unsigned TIMEOUT_CYCLES_DEF = 1024;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DREQ   = 2'd1,
      DRAIN  = 2'd2,
      HALTED = 2'd3
   } req_state_t;

endpackage

// File: rtl/request_unit_if.sv
// request_unit_if: pipeline/hazard-side view of the memory request unit.
// With REQ_TIMEOUT_EN defined, the sticky req_timeout flag is added.
interface request_unit_if
   import request_unit_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEF
);
   logic             load_MEM;
   logic             dREN_EX;
   logic             dWEN_EX;
   logic             halt_EX;
   logic             ihit;
   logic             dhit;
   logic             imemREN;
   logic             dmemREN;
   logic             dmemWEN;
   logic             halt;
   logic             req_err;
   logic [CNT_W-1:0] dwait_cnt;
`ifdef REQ_TIMEOUT_EN
   logic             req_timeout;
`endif

   modport ru (
      input  load_MEM, dREN_EX, dWEN_EX, halt_EX, ihit, dhit,
`ifdef REQ_TIMEOUT_EN
      output req_timeout,
`endif
      output imemREN, dmemREN, dmemWEN, halt, req_err, dwait_cnt
   );

   modport tb (
      output load_MEM, dREN_EX, dWEN_EX, halt_EX, ihit, dhit,
`ifdef REQ_TIMEOUT_EN
      input  req_timeout,
`endif
      input  imemREN, dmemREN, dmemWEN, halt, req_err, dwait_cnt
   );

endinterface

// File: rtl/request_unit_timeout_counter.sv
// req_timeout_counter: reloadable down-counter; expired_c pulses on the tick
// that consumes the last remaining cycle.
module req_timeout_counter #(
   parameter int unsigned LIMIT = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic reload,
   input  logic tick,
   output logic expired_c
);
   localparam int unsigned TW = $clog2(LIMIT + 1);

   logic [TW-1:0] remain_q;

   // Reload takes priority; ticks count down and stop at zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         remain_q <= '0;
      end else if (reload) begin
         remain_q <= TW'(LIMIT);
      end else if (tick && remain_q != '0) begin
         remain_q <= remain_q - TW'(1);
      end
   end

   assign expired_c = tick && (remain_q == TW'(1));

endmodule

// File: rtl/request_unit.sv
// request_unit: data/instruction memory request generator with halt tracking.
// Define REQ_TIMEOUT_EN to add the req_timeout flag and its timer.
module request_unit
   import request_unit_pkg::*;
#(
   parameter int unsigned CNT_W          = CNT_W_DEF,
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input logic        CLK,
   input logic        RST,
   request_unit_if.ru bus
);
   req_state_t       state_q;
   logic             imem_ren_q;
   logic             dmem_ren_q;
   logic             dmem_wen_q;
   logic             halt_q;
   logic             req_err_q;
   logic [CNT_W-1:0] dwait_q;

   logic mem_op_c;
   logic busy_c;
   logic issue_c;
   logic halt_ld_c;
   logic unused_c;

   assign mem_op_c  = bus.load_MEM & (bus.dREN_EX | bus.dWEN_EX);
   assign halt_ld_c = bus.load_MEM & bus.halt_EX;
   assign busy_c    = (state_q == DREQ) || (state_q == DRAIN);
   assign issue_c   = mem_op_c & ((state_q == IDLE) | ((state_q == DREQ) & bus.dhit));
   assign unused_c  = ^{bus.ihit, TIMEOUT_CYCLES[0]};

   // Request FSM with registered strobes, halt, error flag and wait counter.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= IDLE;
         imem_ren_q <= 1'b1;
         dmem_ren_q <= 1'b0;
         dmem_wen_q <= 1'b0;
         halt_q     <= 1'b0;
         req_err_q  <= 1'b0;
         dwait_q    <= '0;
      end else begin
         if (busy_c && !bus.dhit && dwait_q != '1) begin
            dwait_q <= dwait_q + CNT_W'(1);
         end
         if (issue_c) begin
            state_q    <= DREQ;
            dmem_wen_q <= bus.dWEN_EX;
            dmem_ren_q <= ~bus.dWEN_EX;
            if (bus.dREN_EX && bus.dWEN_EX) begin
               req_err_q <= 1'b1;
            end
         end else begin
            case (state_q)
               IDLE: begin
                  if (halt_ld_c) begin
                     state_q    <= HALTED;
                     halt_q     <= 1'b1;
                     imem_ren_q <= 1'b0;
                  end
               end
               DREQ: begin
                  if (bus.dhit) begin
                     dmem_ren_q <= 1'b0;
                     dmem_wen_q <= 1'b0;
                     if (halt_ld_c) begin
                        state_q    <= HALTED;
                        halt_q     <= 1'b1;
                        imem_ren_q <= 1'b0;
                     end else begin
                        state_q <= IDLE;
                     end
                  end else if (halt_ld_c) begin
                     state_q <= DRAIN;
                  end
               end
               DRAIN: begin
                  if (bus.dhit) begin
                     state_q    <= HALTED;
                     dmem_ren_q <= 1'b0;
                     dmem_wen_q <= 1'b0;
                     halt_q     <= 1'b1;
                     imem_ren_q <= 1'b0;
                  end
               end
               HALTED: begin
               end
               default: begin
                  state_q <= IDLE;
               end
            endcase
         end
      end
   end

   assign bus.imemREN   = imem_ren_q;
   assign bus.dmemREN   = dmem_ren_q;
   assign bus.dmemWEN   = dmem_wen_q;
   assign bus.halt      = halt_q;
   assign bus.req_err   = req_err_q;
   assign bus.dwait_cnt = dwait_q;

`ifdef REQ_TIMEOUT_EN
   logic expired_c;
   logic timeout_q;

   req_timeout_counter #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk       (CLK),
      .rst       (RST),
      .reload    (issue_c),
      .tick      (busy_c & ~bus.dhit),
      .expired_c (expired_c)
   );

   // Sticky timeout flag; the request itself stays asserted.
   always_ff @(posedge CLK) begin
      if (RST) begin
         timeout_q <= 1'b0;
      end else if (expired_c) begin
         timeout_q <= 1'b1;
      end
   end

   assign bus.req_timeout = timeout_q;
`endif

endmodule

// File: tb/tb_request_unit.sv
// tb_request_unit: directed + randomized checks of request_unit against a
// transaction-level reference model. Honors REQ_TIMEOUT_EN.
module tb_request_unit;

   localparam int unsigned CW  = 4;
   localparam int unsigned TO  = 8;
   localparam int          SAT = (1 << CW) - 1;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   request_unit_if #(.CNT_W(CW)) bus ();

   request_unit #(
      .CNT_W          (CW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus.ru)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: the outstanding request as a read/write flag pair.
   bit m_rd, m_wr, m_halt, m_err, m_drain, m_tmo;
   int m_cnt, m_age;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic issue(input bit r, input bit w);
      m_wr  = w;
      m_rd  = !w;
      m_age = 0;
      if (r && w) m_err = 1'b1;
   endtask

   task automatic model(input bit rs, input bit ld, input bit r, input bit w, input bit h, input bit dh);
      bit pending;
      bit memop;
      if (rs) begin
         m_rd = 0; m_wr = 0; m_halt = 0; m_err = 0; m_drain = 0; m_tmo = 0;
         m_cnt = 0; m_age = 0;
         return;
      end
      if (m_halt) return;
      pending = m_rd || m_wr;
      memop   = ld && (r || w);
      if (pending && !dh) begin
         if (m_cnt < SAT) m_cnt++;
         m_age++;
         if (m_age == TO) m_tmo = 1'b1;
      end
      if (!pending) begin
         if (memop) issue(r, w);
         else if (ld && h) m_halt = 1'b1;
      end else if (dh) begin
         m_rd = 0;
         m_wr = 0;
         if (m_drain) m_halt = 1'b1;
         else if (memop) issue(r, w);
         else if (ld && h) m_halt = 1'b1;
      end else if (ld && h) begin
         m_drain = 1'b1;
      end
   endtask

   task automatic compare_all();
      check("imemREN", 32'(bus.imemREN), 32'(!m_halt));
      check("dmemREN", 32'(bus.dmemREN), 32'(m_rd));
      check("dmemWEN", 32'(bus.dmemWEN), 32'(m_wr));
      check("halt", 32'(bus.halt), 32'(m_halt));
      check("req_err", 32'(bus.req_err), 32'(m_err));
      check("dwait_cnt", 32'(bus.dwait_cnt), 32'(m_cnt));
      check("strobe_excl", 32'(bus.dmemREN & bus.dmemWEN), 32'd0);
`ifdef REQ_TIMEOUT_EN
      check("req_timeout", 32'(bus.req_timeout), 32'(m_tmo));
`endif
   endtask

   // One clock: drive after negedge, update model at posedge, sample #1 later.
   task automatic step(input bit rs, input bit ld, input bit r, input bit w, input bit h, input bit dh);
      rst          = rs;
      bus.load_MEM = ld;
      bus.dREN_EX  = r;
      bus.dWEN_EX  = w;
      bus.halt_EX  = h;
      bus.dhit     = dh;
      bus.ihit     = 1'($urandom_range(0, 1));
      @(posedge clk);
      model(rs, ld, r, w, h, dh);
      #1;
      compare_all();
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
   endtask

   int hi_cycles;
   bit r_rs, r_ld, r_r, r_w, r_h, r_dh;
   int kind;

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst = 1'b1;
      bus.load_MEM = 0; bus.dREN_EX = 0; bus.dWEN_EX = 0;
      bus.halt_EX = 0; bus.dhit = 0; bus.ihit = 0;
      @(negedge clk);

      // Reset state
      step(1, 0, 0, 0, 0, 0);
      check("rst_imemREN", 32'(bus.imemREN), 32'd1);
      check("rst_dwait", 32'(bus.dwait_cnt), 32'd0);

      // Reset with a load pending
      step(0, 1, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      check("rstpend_dmemREN", 32'(bus.dmemREN), 32'd0);
      check("rstpend_imemREN", 32'(bus.imemREN), 32'd1);
      check("rstpend_dwait", 32'(bus.dwait_cnt), 32'd0);

      // Single load, dhit on the fourth request cycle
      hi_cycles = 0;
      step(0, 1, 1, 0, 0, 0);
      hi_cycles += int'(bus.dmemREN);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 0, 0, 0);
         hi_cycles += int'(bus.dmemREN);
      end
      step(0, 0, 0, 0, 0, 1);
      hi_cycles += int'(bus.dmemREN);
      check("single_hi_cycles", 32'(hi_cycles), 32'd4);
      check("single_dwait", 32'(bus.dwait_cnt), 32'd3);
      check("single_idle", 32'(bus.dmemREN | bus.dmemWEN), 32'd0);

      // Back-to-back store after load
      step(0, 1, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      step(0, 1, 0, 1, 0, 1);
      check("b2b_dmemREN", 32'(bus.dmemREN), 32'd0);
      check("b2b_dmemWEN", 32'(bus.dmemWEN), 32'd1);
      step(0, 0, 0, 0, 0, 1);

      // Conflicting request: write wins, error is sticky
      step(0, 1, 1, 1, 0, 0);
      check("conf_dmemWEN", 32'(bus.dmemWEN), 32'd1);
      check("conf_dmemREN", 32'(bus.dmemREN), 32'd0);
      check("conf_err", 32'(bus.req_err), 32'd1);
      step(0, 0, 0, 0, 0, 1);
      idle(3);
      check("conf_err_sticky", 32'(bus.req_err), 32'd1);

      // Wait counter saturates at all-ones
      step(1, 0, 0, 0, 0, 0);
      step(0, 1, 1, 0, 0, 0);
      idle(SAT + 5);
      check("sat_dwait", 32'(bus.dwait_cnt), 32'(SAT));
      step(0, 0, 0, 0, 0, 1);

      // Halt behind a pending load
      step(1, 0, 0, 0, 0, 0);
      step(0, 1, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 1, 1);
      check("halt_halt", 32'(bus.halt), 32'd1);
      check("halt_imemREN", 32'(bus.imemREN), 32'd0);
      step(0, 1, 1, 0, 0, 1);
      step(0, 1, 0, 1, 0, 0);
      check("halt_ignore_ren", 32'(bus.dmemREN | bus.dmemWEN), 32'd0);
      check("halt_stays", 32'(bus.halt), 32'd1);

      // Halt loaded without dhit drains the request first
      step(1, 0, 0, 0, 0, 0);
      step(0, 1, 0, 1, 0, 0);
      step(0, 1, 0, 0, 1, 0);
      check("drain_wen_held", 32'(bus.dmemWEN), 32'd1);
      check("drain_no_halt", 32'(bus.halt), 32'd0);
      step(0, 0, 0, 0, 0, 1);
      check("drain_halt", 32'(bus.halt), 32'd1);

`ifdef REQ_TIMEOUT_EN
      // Timeout after TO cycles without dhit
      step(1, 0, 0, 0, 0, 0);
      step(0, 1, 1, 0, 0, 0);
      idle(TO - 1);
      check("to_not_yet", 32'(bus.req_timeout), 32'd0);
      step(0, 0, 0, 0, 0, 0);
      check("to_flag", 32'(bus.req_timeout), 32'd1);
      check("to_dmemREN", 32'(bus.dmemREN), 32'd1);
      step(0, 0, 0, 0, 0, 1);
      check("to_sticky", 32'(bus.req_timeout), 32'd1);
      // dhit on the expiry cycle wins
      step(1, 0, 0, 0, 0, 0);
      step(0, 1, 1, 0, 0, 0);
      idle(TO - 1);
      step(0, 0, 0, 0, 0, 1);
      check("to_dhit_wins", 32'(bus.req_timeout), 32'd0);
`endif

      // Randomized traffic against the model
      step(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3000; i++) begin
         r_rs = m_halt ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 199) == 0);
         r_ld = ($urandom_range(0, 1) == 1);
         kind = int'($urandom_range(0, 19));
         r_r  = (kind < 8) || (kind == 18);
         r_w  = (kind >= 8 && kind < 16) || (kind == 18);
         r_h  = (kind == 19);
         r_dh = ($urandom_range(0, 99) < 30);
         step(r_rs, r_ld, r_r, r_w, r_h, r_dh);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/request_unit.md
Name: request_unit

Overview:
- Memory-side request generator for the pipelined datapath.
- Drives instruction and data memory request strobes (imemREN, dmemREN, dmemWEN) to the cache/memory controller.
- Holds each data request until dhit, then retires it.
- Tracks halt and exports registered request state (dmemREN/dmemWEN) back to the hazard unit, which uses it to decide stalls and flushes.

Parameters:
- CNT_W, 32, width of the saturating data-wait cycle counter.
- TIMEOUT_CYCLES, 1024, cycles a data request may stay outstanding before timeout (used only with the optional feature).

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  synchronous, active-high reset.
- load_MEM  input  1  EX/MEM latch loads a new instruction this cycle; equals hazard unit enable_EX_MEM and not flush_EX_MEM.
- dREN_EX  input  1  the instruction being loaded is a load (lw/ll).
- dWEN_EX  input  1  the instruction being loaded is a store (sw/sc).
- halt_EX  input  1  the instruction being loaded is HALT.
- ihit  input  1  instruction cache hit/return.
- dhit  input  1  data cache hit/return.
- imemREN  output  1  instruction fetch request.
- dmemREN  output  1  registered data read request.
- dmemWEN  output  1  registered data write request.
- halt  output  1  sticky halt indication to the hazard unit and top level.
- req_err  output  1  sticky flag: dREN_EX and dWEN_EX were both high on a load.
- dwait_cnt  output  CNT_W  saturating count of cycles with a data request outstanding and no dhit.

Behaviour:
- Reset (RST high at a CLK edge):
  - state=IDLE; dmemREN=dmemWEN=halt=req_err=0; dwait_cnt=0; imemREN=1.
  - Reset mid-request drops the request immediately; no dhit is awaited.
- States: IDLE, DREQ, DRAIN, HALTED. Encoding is a package enum.
- IDLE:
  - load_MEM with dWEN_EX: dmemWEN<=1 next cycle, go to DREQ.
  - Otherwise load_MEM with dREN_EX: dmemREN<=1, go to DREQ.
  - Both dREN_EX and dWEN_EX high: write wins and req_err<=1.
  - load_MEM with halt_EX: go to HALTED.
  - Request latency: strobe is visible 1 cycle after the load_MEM edge.
- DREQ:
  - Strobes hold steady until dhit.
  - dhit with no load_MEM: clear both strobes, go to IDLE.
  - dhit together with a load_MEM memory op: back-to-back. The strobes reload with the new op, state stays DREQ, and there is no idle gap.
  - dhit together with load_MEM halt_EX: clear strobes, go to HALTED.
  - load_MEM without dhit is illegal, because the hazard unit must stall on an outstanding request. Ignore it and keep the current request.
- DRAIN: entered when halt_EX loads while a data request is outstanding; the request waits for dhit, then the block goes to HALTED. This path is only reachable if the hazard unit mis-stalls and the illegal load_MEM case occurs. It is kept for robustness.
- HALTED: halt=1, imemREN=0, dmemREN=dmemWEN=0. Stays here until RST; all inputs are ignored.
- imemREN: 1 in every state except HALTED. ihit does not affect it.
- dwait_cnt:
  - Increments in DREQ/DRAIN on each cycle dhit=0.
  - Saturates at all-ones and never wraps.
  - Cleared only by RST.
- At no time are dmemREN and dmemWEN both 1.

Optional Feature:
- Macro: REQ_TIMEOUT_EN.
- Defined:
  - Adds output req_timeout (1 bit) and a timer reloaded on every request issue.
  - If a request stays outstanding for TIMEOUT_CYCLES consecutive cycles without dhit, req_timeout<=1 (sticky until RST). The request stays asserted.
  - dhit on the exact expiry cycle wins, and no timeout is flagged.
- Undefined: no port, no timer logic. Behaviour is otherwise identical.

Decomposition:
- New package request_unit_pkg:
  - req_state_t enum (IDLE, DREQ, DRAIN, HALTED).
  - Localparam for the default TIMEOUT_CYCLES.
- Interface request_unit_if with ru and tb modports, consistent with the hazard unit interface; dmemREN/dmemWEN connect to the hazard unit's inputs of the same name.
- One sub-module, req_timeout_counter: a reloadable down-counter with an expiry flag. It is instantiated only under REQ_TIMEOUT_EN.

Test Plan:
- Reset with a request pending:
  - Stimulus: load a lw, then assert RST before dhit.
  - Required: the next cycle dmemREN=0, imemREN=1, dwait_cnt=0.
- Single load:
  - Stimulus: load_MEM=1 with dREN_EX=1, dhit arrives after 3 cycles.
  - Required: dmemREN=1 for exactly 4 cycles, dwait_cnt=3, return to IDLE.
- Back-to-back store after load:
  - Stimulus: dhit and load_MEM with dWEN_EX=1 in the same cycle.
  - Required: the next cycle dmemREN=0 and dmemWEN=1, with no idle cycle between.
- Conflicting request:
  - Stimulus: dREN_EX=1 and dWEN_EX=1 together on a load.
  - Required: dmemWEN=1, dmemREN=0, req_err=1 and sticky.
- Halt behind a pending load:
  - Stimulus: halt_EX loaded together with the dhit of a pending lw.
  - Required: the next cycle halt=1, imemREN=0, and all later inputs are ignored.
- Timeout (REQ_TIMEOUT_EN, TIMEOUT_CYCLES=8):
  - Stimulus: withhold dhit for 8 cycles.
  - Required: req_timeout=1, dmemREN stays 1.
  - Stimulus: repeat with dhit on cycle 8.
  - Required: req_timeout=0.
